div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 23 ++
 rtl/div.sv | 134 +++++++++++++
 tb/tb_div.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM states and
// handshake level names.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree    = 2'b00,
        DivByZero  = 2'b01,
        DivOn      = 2'b10,
        DivEnd     = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [5:0] DivIterations = 6'd32;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div.sv
// 32-bit signed/unsigned divider, one quotient bit per clock (restoring).
// result_o = {remainder, quotient}; ready_o marks it valid until start_i drops.
//
// state     | meaning
// DivFree   | idle, waiting for start_i
// DivByZero | divisor was zero, zero result issued next edge
// DivOn     | 32 restoring iterations, then sign correction
// DivEnd    | result held until start_i is released
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state_q, state_d;
    logic [64:0] shreg_q, shreg_d;
    logic [31:0] divisor_q, divisor_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic        signed_q, signed_d;
    logic [63:0] result_d;
    logic        ready_d;

    logic [32:0] diff;
    logic [31:0] mag1, mag2;
    logic [31:0] quo_fix, rem_fix;

    assign diff = {1'b0, shreg_q[63:32]} - {1'b0, divisor_q};
    assign mag1 = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
    assign quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? neg32(shreg_q[31:0]) : shreg_q[31:0];
    assign rem_fix = (signed_q && sign1_q) ? neg32(shreg_q[64:33]) : shreg_q[64:33];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            shreg_q   <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            signed_q  <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            signed_q  <= signed_d;
            result_o  <= result_d;
            ready_o   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        signed_d  = signed_q;
        result_d  = result_o;
        ready_d   = ready_o;

        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                        // Low zero pre-shifts the dividend so each iteration
                        // compares the next partial remainder directly.
                        shreg_d   = {32'd0, mag1, 1'b0};
                        divisor_d = mag2;
                        sign1_d   = opdata1_i[31];
                        sign2_d   = opdata2_i[31];
                        signed_d  = signed_div_i;
                        cnt_d     = '0;
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    shreg_d  = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q != DivIterations) begin
                    if (diff[32])
                        shreg_d = {shreg_q[63:0], 1'b0};
                    else
                        shreg_d = {diff[31:0], shreg_q[31:0], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DivEnd;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                    cnt_d    = '0;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: state_d = DivFree;
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Randomized scoreboard bench for div: expected results come from plain
// integer division and are checked by an independent monitor.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [63:0] held_val;
    logic        ready_prev = 1'b0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation on each ready rise, then checks that the
    // result holds for as long as ready stays high.
    always @(negedge clk) begin
        if (ready_o && !ready_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %h with no division pending", result_o);
            end else begin
                held_val = exp_q.pop_front();
                check("result", result_o, held_val);
            end
        end else if (ready_o && ready_prev) begin
            check("result_hold", result_o, held_val);
        end
        ready_prev <= ready_o;
    end

    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        int cycles;
        int lat;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        exp_q.push_back(ref_div(sgn, a, b));
        lat = (b == 32'd0) ? 2 : 34;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = ~sgn;
            end
        end while (!ready_o && cycles < 100);
        if (!ready_o) begin
            check("ready_timeout", 64'(ready_o), 64'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
            check("latency", 64'(cycles), 64'(lat));
        end
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("ready_drop", 64'(ready_o), 64'd0);
        check("result_clear", result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit          sgn;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        check("ref_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        do_div(1'b0, 32'd100, 32'd7, 2);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 1);
        do_div(1'b0, 32'hFFFFFFF9, 32'd2, 0);
        do_div(1'b0, 32'd12345, 32'd0, 3);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1);
        do_div(1'b1, 32'hFFFFFFF9, 32'd100, 1);
        do_div(1'b0, 32'd5, 32'hFFFFFFFF, 0);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 0);

        // Cancel mid-division: no result may appear.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        repeat (40) @(negedge clk);
        check("annul_no_ready", 64'(ready_o), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, 1);

        // Asynchronous reset mid-division.
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        start_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_mid_no_ready", 64'(ready_o), 64'd0);
        do_div(1'b1, 32'hFFFFFC18, 32'd3, 0);

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd77;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        exp_q.push_back(64'd0);
        opdata1_i = 32'd77;
        @(negedge clk);
        @(negedge clk);
        check("div0_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_div(1'b0, 32'd1, 32'd1, 0);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: b = a + 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            do_div(sgn, a, b, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
